// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and port indices for the data memory arbiter
package dmem_arb_pkg;
    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check: byte address to word index translation with alignment and range check
module dmem_addr_check #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] addr,
    output logic [ADDR_W-1:0] idx,
    output logic              err
);
    assign idx = addr[ADDR_W+1:2];
    assign err = (addr[1:0] != 2'b00) || (addr[DATA_W-1:ADDR_W+2] != '0);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter with lock in front of a single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic              rerr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic              rerr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do
);
    logic [ADDR_W-1:0] w_idx0, w_idx1;
    logic              w_err0, w_err1, w_can0, w_can1;
    logic [1:0]        r_state;
    logic              r_ptr;

    dmem_addr_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk0 (.addr(addr0), .idx(w_idx0), .err(w_err0));
    dmem_addr_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk1 (.addr(addr1), .idx(w_idx1), .err(w_err1));

    // a lock held by one port masks the other port entirely; reset masks both
    assign w_can0 = req0 && !reset && (r_state != LOCK1);
    assign w_can1 = req1 && !reset && (r_state != LOCK0);
    assign gnt0   = w_can0 && (!w_can1 || r_ptr == PORT_CPU);
    assign gnt1   = w_can1 && (!w_can0 || r_ptr == PORT_DBG);

    // port 0 fields drive the memory whenever port 1 is not the winner
    assign mem_addr = {{(DATA_W-ADDR_W){1'b0}}, gnt1 ? w_idx1 : w_idx0};
    assign mem_di   = gnt1 ? wdata1 : wdata0;
    assign mem_we   = gnt0 ? (we0 && !w_err0) : (gnt1 && we1 && !w_err1);

    // priority pointer flips after every grant; lock state follows the winner's lock bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB;
            r_ptr   <= PORT_CPU;
        end else begin
            if (gnt0 || gnt1)
                r_ptr <= gnt0 ? PORT_DBG : PORT_CPU;
            if (gnt0)
                r_state <= lock0 ? LOCK0 : ARB;
            else if (gnt1)
                r_state <= lock1 ? LOCK1 : ARB;
        end
    end

    // one-cycle response per grant; rdata only carries clean load data and holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rerr0   <= 1'b0;
            rerr1   <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0) begin
                rerr0  <= w_err0;
                rdata0 <= (we0 || w_err0) ? '0 : mem_do;
            end
            if (gnt1) begin
                rerr1  <= w_err1;
                rdata1 <= (we1 || w_err1) ? '0 : mem_do;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset, fill;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, rerr0, gnt1, rvalid1, rerr1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_di, mem_do;
    logic [31:0] mem [64];
    int vec = 0;
    int miss = 0;

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rerr0(rerr0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rerr1(rerr1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill)
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
        else if (mem_we)
            mem[mem_addr[5:0]] <= mem_di;
    end
    assign mem_do = mem[mem_addr[5:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset;
        reset = 1; fill = 1;
        req0 = 1; we0 = 1; lock0 = 0; addr0 = 32'h0; wdata0 = 32'hFFFF_FFFF;
        req1 = 1; we1 = 1; lock1 = 0; addr1 = 32'h4; wdata1 = 32'hEEEE_EEEE;
        #1;
        vec++; if ({gnt0, gnt1, mem_we} !== 3'b000) begin miss++; $display("FAIL rst_gnt: got %b want 000", {gnt0, gnt1, mem_we}); end
        tick();
        fill = 0;
        vec++; if ({rvalid0, rvalid1, rerr0, rerr1} !== 4'b0000) begin miss++; $display("FAIL rst_resp: got %b want 0000", {rvalid0, rvalid1, rerr0, rerr1}); end
        vec++; if ({rdata0, rdata1} !== 64'h0) begin miss++; $display("FAIL rst_rdata: got %h want 0", {rdata0, rdata1}); end
        tick();
        vec++; if (mem[0] !== 32'h1000_0000 || mem[1] !== 32'h1000_0001) begin miss++; $display("FAIL rst_nowrite: got %h %h want 10000000 10000001", mem[0], mem[1]); end
        reset = 0;
        idle();
    endtask

    task automatic test_store_load;
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        #1;
        vec++; if ({gnt0, gnt1, mem_we} !== 3'b101) begin miss++; $display("FAIL st_gnt: got %b want 101", {gnt0, gnt1, mem_we}); end
        vec++; if (mem_addr !== 32'd4 || mem_di !== 32'hDEAD_BEEF) begin miss++; $display("FAIL st_bus: got %h %h want 4 deadbeef", mem_addr, mem_di); end
        tick();
        vec++; if ({rvalid0, rerr0, rvalid1} !== 3'b100 || rdata0 !== 32'h0) begin miss++; $display("FAIL st_resp: got %b %h want 100 0", {rvalid0, rerr0, rvalid1}, rdata0); end
        we0 = 0;
        #1;
        vec++; if ({gnt0, mem_we} !== 2'b10) begin miss++; $display("FAIL ld_gnt: got %b want 10", {gnt0, mem_we}); end
        tick();
        vec++; if ({rvalid0, rerr0} !== 2'b10 || rdata0 !== 32'hDEAD_BEEF) begin miss++; $display("FAIL ld_data: got %b %h want 10 deadbeef", {rvalid0, rerr0}, rdata0); end
        idle();
        tick();
        vec++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin miss++; $display("FAIL ld_hold: got %b %h want 0 deadbeef", rvalid0, rdata0); end
    endtask

    task automatic test_round_robin;
        do_reset();
        req0 = 1; addr0 = 32'h10;
        req1 = 1; addr1 = 32'h00;
        for (int c = 0; c < 4; c++) begin
            #1;
            vec++; if ({gnt0, gnt1} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin miss++; $display("FAIL rr_gnt%0d: got %b", c, {gnt0, gnt1}); end
            tick();
            vec++; if ({rvalid0, rvalid1} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin miss++; $display("FAIL rr_rvalid%0d: got %b", c, {rvalid0, rvalid1}); end
            if (c % 2 == 0) begin
                vec++; if (rdata0 !== 32'hDEAD_BEEF) begin miss++; $display("FAIL rr_rdata0_%0d: got %h want deadbeef", c, rdata0); end
            end else begin
                vec++; if (rdata1 !== 32'h1000_0000) begin miss++; $display("FAIL rr_rdata1_%0d: got %h want 10000000", c, rdata1); end
            end
        end
        idle();
    endtask

    task automatic test_errors;
        req1 = 1; we1 = 1; addr1 = 32'h12; wdata1 = 32'h1111_1111;
        #1;
        vec++; if ({gnt0, gnt1, mem_we} !== 3'b010) begin miss++; $display("FAIL mis_gnt: got %b want 010", {gnt0, gnt1, mem_we}); end
        tick();
        vec++; if ({rvalid1, rerr1} !== 2'b11 || rdata1 !== 32'h0) begin miss++; $display("FAIL mis_resp: got %b %h want 11 0", {rvalid1, rerr1}, rdata1); end
        addr1 = 32'h100;
        #1;
        vec++; if ({gnt0, gnt1, mem_we} !== 3'b010) begin miss++; $display("FAIL oor_gnt: got %b want 010", {gnt0, gnt1, mem_we}); end
        tick();
        vec++; if ({rvalid1, rerr1} !== 2'b11 || rdata1 !== 32'h0) begin miss++; $display("FAIL oor_resp: got %b %h want 11 0", {rvalid1, rerr1}, rdata1); end
        idle();
        vec++; if (mem[4] !== 32'hDEAD_BEEF || mem[0] !== 32'h1000_0000) begin miss++; $display("FAIL err_mem: got %h %h want deadbeef 10000000", mem[4], mem[0]); end
    endtask

    task automatic test_lock;
        req0 = 1; addr0 = 32'h00;
        #1;
        vec++; if ({gnt0, gnt1} !== 2'b10) begin miss++; $display("FAIL lk_pre: got %b want 10", {gnt0, gnt1}); end
        tick();
        req1 = 1; lock1 = 1; addr1 = 32'h20;
        #1;
        vec++; if ({gnt0, gnt1} !== 2'b01) begin miss++; $display("FAIL lk_take: got %b want 01", {gnt0, gnt1}); end
        tick();
        vec++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h1000_0008) begin miss++; $display("FAIL lk_ld: got %b %h want 1 10000008", rvalid1, rdata1); end
        req1 = 0;
        #1;
        vec++; if ({gnt0, gnt1} !== 2'b00) begin miss++; $display("FAIL lk_hold: got %b want 00", {gnt0, gnt1}); end
        tick();
        req1 = 1; we1 = 1; lock1 = 0; wdata1 = 32'hCAFE_F00D;
        #1;
        vec++; if ({gnt0, gnt1, mem_we} !== 3'b011) begin miss++; $display("FAIL lk_rel: got %b want 011", {gnt0, gnt1, mem_we}); end
        tick();
        vec++; if ({rvalid1, rerr1} !== 2'b10 || mem[8] !== 32'hCAFE_F00D) begin miss++; $display("FAIL lk_st: got %b %h want 10 cafef00d", {rvalid1, rerr1}, mem[8]); end
        req1 = 0; we1 = 0;
        #1;
        vec++; if ({gnt0, gnt1} !== 2'b10) begin miss++; $display("FAIL lk_after: got %b want 10", {gnt0, gnt1}); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_lock;
        req0 = 1; lock0 = 1; addr0 = 32'h10;
        #1;
        vec++; if (gnt0 !== 1'b1) begin miss++; $display("FAIL ml_gnt: got %b want 1", gnt0); end
        tick();
        reset = 1;
        #1;
        vec++; if ({gnt0, mem_we} !== 2'b00) begin miss++; $display("FAIL ml_rst_gnt: got %b want 00", {gnt0, mem_we}); end
        tick();
        vec++; if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin miss++; $display("FAIL ml_drop: got %b %h want 0 0", rvalid0, rdata0); end
        reset = 0; lock0 = 0;
        req1 = 1; addr1 = 32'h20;
        #1;
        vec++; if ({gnt0, gnt1} !== 2'b10) begin miss++; $display("FAIL ml_first: got %b want 10", {gnt0, gnt1}); end
        tick();
        #1;
        vec++; if ({gnt0, gnt1} !== 2'b01) begin miss++; $display("FAIL ml_arb: got %b want 01", {gnt0, gnt1}); end
        tick();
        vec++; if (rdata0 !== 32'hDEAD_BEEF || rdata1 !== 32'hCAFE_F00D) begin miss++; $display("FAIL ml_data: got %h %h want deadbeef cafef00d", rdata0, rdata1); end
        idle();
    endtask

    task automatic test_top_word;
        req0 = 1; we0 = 1; addr0 = 32'hFC; wdata0 = 32'h5A5A_A5A5;
        #1;
        vec++; if (mem_addr !== 32'd63 || {gnt0, mem_we} !== 2'b11) begin miss++; $display("FAIL tw_bus: got %h %b want 3f 11", mem_addr, {gnt0, mem_we}); end
        tick();
        we0 = 0;
        tick();
        vec++; if ({rvalid0, rerr0} !== 2'b10 || rdata0 !== 32'h5A5A_A5A5) begin miss++; $display("FAIL tw_ld: got %b %h want 10 5a5aa5a5", {rvalid0, rerr0}, rdata0); end
        addr0 = 32'h00;
        tick();
        vec++; if (rdata0 !== 32'h1000_0000) begin miss++; $display("FAIL tw_alias: got %h want 10000000", rdata0); end
        idle();
    endtask

    task automatic test_back_to_back;
        req0 = 1; we0 = 1; addr0 = 32'h24; wdata0 = 32'h0BAD_CAFE;
        tick();
        req0 = 0; we0 = 0;
        req1 = 1; addr1 = 32'h24;
        #1;
        vec++; if (gnt1 !== 1'b1) begin miss++; $display("FAIL bb_gnt: got %b want 1", gnt1); end
        tick();
        vec++; if ({rvalid1, rerr1} !== 2'b10 || rdata1 !== 32'h0BAD_CAFE) begin miss++; $display("FAIL bb_data: got %b %h want 10 0badcafe", {rvalid1, rerr1}, rdata1); end
        idle();
        tick();
    endtask

    initial begin
        idle();
        reset = 1; fill = 1;
        test_reset();
        test_store_load();
        test_round_robin();
        test_errors();
        test_lock();
        test_reset_mid_lock();
        test_top_word();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
